// File: rtl/tdm_receive_framed.sv
// tdm_receive_framed: TDM serial-audio deserialiser with frame-sync lock and error tracking.
// Ports:
//   clk_in, rst_n_in        system clock, async active-low reset
//   sck_in, ws_in, sd_in    async serial bus (bit clock, frame sync, data)
//   audio_out               last complete frame, audio_out[k] = slot k word
//   audio_valid_out         1-cycle pulse when audio_out updates
//   locked_out              high while frame sync is tracked
//   frame_err_out           1-cycle pulse on an early or missing ws rise
//   err_count_out           saturating error count, present only with TDM_RX_ERR_COUNT_EN defined
module tdm_receive_framed #(
  parameter int BIT_WIDTH  = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int SLOTS      = 4,
  parameter int DATA_DELAY = 1
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic                                sck_in,
  input  logic                                ws_in,
  input  logic                                sd_in,
  output logic [SLOTS-1:0][BIT_WIDTH-1:0]     audio_out,
  output logic                                audio_valid_out,
  output logic                                locked_out,
  output logic                                frame_err_out
`ifdef TDM_RX_ERR_COUNT_EN
  ,
  output logic [15:0]                         err_count_out
`endif
);
  localparam int PW = $clog2(SLOT_WIDTH + 1);
  localparam int SW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  typedef enum logic [1:0] {IDLE, ARM, RUN} state_t;
  state_t state, state_nxt;
  logic [2:0] sck_q;
  logic [1:0] ws_q, sd_q;
  logic ws_last;
  logic [PW-1:0] pos;
  logic [SW-1:0] slot;
  logic [SLOTS-1:0][BIT_WIDTH-1:0] shadow, sh_nxt;
  logic sck_rise, ws_rise, first, last_pos, last, expd;
  logic start, adv, clr, pub, err, lock_set, lock_clr;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign ws_rise  = sck_rise & ws_q[1] & ~ws_last;
  assign first    = pos == '0 && slot == '0;
  assign last_pos = pos == PW'(SLOT_WIDTH - 1);
  assign last     = last_pos && slot == SW'(SLOTS - 1);
  // the point where the next frame's ws rise belongs: on the final bit when
  // the MSB is delayed by one sck, otherwise on the wrapped bit 0
  assign expd     = DATA_DELAY != 0 ? last : first;
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state <= IDLE;
    else state <= state_nxt;
  // start: this rise is bit 0 of a fresh frame; adv: ordinary bit in RUN
  always_comb begin
    state_nxt = state;
    start = 1'b0;
    adv = 1'b0;
    clr = 1'b0;
    pub = 1'b0;
    err = 1'b0;
    lock_set = 1'b0;
    lock_clr = 1'b0;
    if (sck_rise)
      case (state)
        IDLE: if (ws_rise) begin
          state_nxt = DATA_DELAY != 0 ? ARM : RUN;
          start = DATA_DELAY == 0;
        end
        ARM: begin
          state_nxt = RUN;
          start = 1'b1;
        end
        default:
          if (ws_rise && !expd) begin
            err = 1'b1;
            lock_clr = 1'b1;
            clr = 1'b1;
            state_nxt = DATA_DELAY != 0 ? ARM : RUN;
            start = DATA_DELAY == 0;
          end else if (!ws_rise && expd) begin
            // delayed mode still owns a completed frame here; undelayed mode
            // published it on the previous rise and only drops back to IDLE
            err = 1'b1;
            lock_clr = 1'b1;
            state_nxt = IDLE;
            adv = DATA_DELAY != 0;
            pub = DATA_DELAY != 0;
            clr = DATA_DELAY == 0;
          end else begin
            adv = 1'b1;
            pub = last;
            lock_set = last;
          end
      endcase
  end
  always_comb begin
    sh_nxt = clr ? '0 : shadow;
    if (start) sh_nxt[0] = BIT_WIDTH'(sd_q[1]);
    else if (adv && pos < PW'(BIT_WIDTH)) sh_nxt[slot] = {shadow[slot][BIT_WIDTH-2:0], sd_q[1]};
  end
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sck_q <= '0;
      ws_q <= '0;
      sd_q <= '0;
      ws_last <= 1'b0;
      pos <= '0;
      slot <= '0;
      shadow <= '0;
      audio_out <= '0;
      audio_valid_out <= 1'b0;
      locked_out <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      sck_q <= {sck_q[1:0], sck_in};
      ws_q <= {ws_q[0], ws_in};
      sd_q <= {sd_q[0], sd_in};
      if (sck_rise) ws_last <= ws_q[1];
      shadow <= sh_nxt;
      if (start) begin
        pos <= PW'(1);
        slot <= '0;
      end else if (adv) begin
        pos <= last_pos ? '0 : pos + 1'b1;
        slot <= last_pos ? (slot == SW'(SLOTS - 1) ? '0 : slot + 1'b1) : slot;
      end
      if (pub) audio_out <= sh_nxt;
      audio_valid_out <= pub;
      frame_err_out <= err;
      locked_out <= lock_clr ? 1'b0 : (lock_set | locked_out);
    end
`ifdef TDM_RX_ERR_COUNT_EN
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) err_count_out <= '0;
    else if (err && err_count_out != 16'hFFFF) err_count_out <= err_count_out + 1'b1;
`endif
endmodule
